if_fetch_buf: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Each cycle it takes the current PC and

---
 rtl/if_fetch_buf.sv | 152 +++++++++++++++
 tb/tb_if_fetch_buf.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: issues PC-addressed reads and tags in-order responses with their address.
// Responses are buffered in a small FIFO for decode; a jump flushes the FIFO and drops in-flight reads.

module if_fetch_buf_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          jump_i,
  input logic          pc_stall_i,
  input logic          rvalid_i,
  input logic [CW-1:0] cnt_i,
  input logic [CW-1:0] pend_i,
  input logic [CW-1:0] drop_i
);
  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(rvalid_i && (pend_i == '0) && (drop_i == '0)));

  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    ((CW + 2)'(cnt_i) + (CW + 2)'(pend_i) + (CW + 2)'(drop_i)) <= (CW + 2)'(DEPTH));

  a_no_stall_on_jump: assert property (@(posedge clk) disable iff (rst)
    !(jump_i && pc_stall_i));
endmodule

module if_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          jump_i,
  output logic          pc_stall_o,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  input  logic          inst_ready_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [AW-1:0] aq_addr_q   [DEPTH];

  logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [CW-1:0] cnt_q, cnt_d, pend_q, pend_d, drop_q, drop_d;

  logic [SW-1:0] occ_s;
  logic          req_s, acc_s, rv_drop_s, rv_take_s, rv_any_s, valid_s, pop_s;

  // Handshake decode; a jump suppresses both the new request and the decode pop
  always_comb begin
    occ_s     = SW'(cnt_q) + SW'(pend_q) + SW'(drop_q);
    req_s     = ~rst & ~jump_i & (occ_s < SW'(DEPTH));
    acc_s     = req_s & imem_gnt_i;
    rv_drop_s = imem_rvalid_i & (drop_q != '0);
    rv_take_s = imem_rvalid_i & (drop_q == '0) & (pend_q != '0);
    rv_any_s  = rv_drop_s | rv_take_s;
    valid_s   = ~rst & ~jump_i & (cnt_q != '0);
    pop_s     = valid_s & inst_ready_i;
  end

  // Next-state for pointers and counters
  always_comb begin
    fifo_rd_d = fifo_rd_q;
    fifo_wr_d = fifo_wr_q;
    aq_rd_d   = aq_rd_q;
    aq_wr_d   = aq_wr_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    if (jump_i) begin
      // Everything still owed by memory becomes a drop; a response this cycle settles one of them
      fifo_rd_d = '0;
      fifo_wr_d = '0;
      aq_rd_d   = '0;
      aq_wr_d   = '0;
      cnt_d     = '0;
      pend_d    = '0;
      drop_d    = drop_q + pend_q - CW'(rv_any_s);
    end else begin
      aq_wr_d   = aq_wr_q + PW'(acc_s);
      aq_rd_d   = aq_rd_q + PW'(rv_take_s);
      fifo_wr_d = fifo_wr_q + PW'(rv_take_s);
      fifo_rd_d = fifo_rd_q + PW'(pop_s);
      pend_d    = pend_q + CW'(acc_s) - CW'(rv_take_s);
      cnt_d     = cnt_q + CW'(rv_take_s) - CW'(pop_s);
      drop_d    = drop_q - CW'(rv_drop_s);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rd_q <= '0;
      fifo_wr_q <= '0;
      aq_rd_q   <= '0;
      aq_wr_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      drop_q    <= '0;
    end else begin
      fifo_rd_q <= fifo_rd_d;
      fifo_wr_q <= fifo_wr_d;
      aq_rd_q   <= aq_rd_d;
      aq_wr_q   <= aq_wr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
    end
  end

  // Storage arrays; visibility is governed by the counters, so contents need no reset
  always_ff @(posedge clk) begin
    if (acc_s) begin
      aq_addr_q[aq_wr_q] <= pc_i;
    end
    if (rv_take_s & ~jump_i) begin
      fifo_data_q[fifo_wr_q] <= imem_rdata_i;
      fifo_addr_q[fifo_wr_q] <= aq_addr_q[aq_rd_q];
    end
  end

  assign imem_req_o   = req_s;
  assign imem_addr_o  = pc_i;
  assign pc_stall_o   = rst | (~jump_i & ~acc_s);
  assign inst_valid_o = valid_s;
  assign inst_o       = fifo_data_q[fifo_rd_q];
  assign inst_addr_o  = fifo_addr_q[fifo_rd_q];

  if_fetch_buf_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .jump_i     (jump_i),
    .pc_stall_i (pc_stall_o),
    .rvalid_i   (imem_rvalid_i),
    .cnt_i      (cnt_q),
    .pend_i     (pend_q),
    .drop_i     (drop_q)
  );
endmodule

// File: tb/tb_if_fetch_buf.sv
// Randomised bench for if_fetch_buf: PC stage + in-order memory model, scoreboard of granted addresses.
module tb_if_fetch_buf;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] pc_q;
  logic          jump_i = 1'b0;
  logic          pc_stall_o;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i = 1'b0;
  logic          imem_rvalid_i = 1'b0;
  logic [DW-1:0] imem_rdata_i = '0;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_addr_o;
  logic          inst_ready_i = 1'b0;
  logic [AW-1:0] jump_tgt = '0;

  typedef struct { logic [AW-1:0] addr; int epoch; } fl_t;
  fl_t           inflight[$];   // requests granted but not yet answered by memory
  logic [AW-1:0] exp_q[$];      // granted, still owed to decode, oldest first
  int            epoch = 0;
  int            tests = 0;
  int            fails = 0;

  if_fetch_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_q),
    .jump_i        (jump_i),
    .pc_stall_o    (pc_stall_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk = ~clk;

  // PC stage: reset to 0, load jump target, otherwise advance unless held
  always @(posedge clk or posedge rst) begin
    if (rst)              pc_q <= '0;
    else if (jump_i)      pc_q <= jump_tgt;
    else if (!pc_stall_o) pc_q <= pc_q + 32'd4;
  end

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive intents at negedge, check combinational outputs against the model, update the model
  task automatic cycle(input bit g, input bit rv, input bit rdy, input bit j, input bit r,
                       input logic [AW-1:0] tgt);
    int live, total, held;
    bit ex_req, rv_fire;
    @(negedge clk);
    rst          = r;
    imem_gnt_i   = g;
    inst_ready_i = rdy;
    jump_i       = j;
    jump_tgt     = tgt;
    rv_fire      = rv && !r && (inflight.size() > 0);
    imem_rvalid_i = rv_fire;
    imem_rdata_i  = rv_fire ? mem_word(inflight[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (inflight[i]) if (inflight[i].epoch == epoch) live++;
    held   = exp_q.size() - live;           // answered, sitting in the buffer
    total  = inflight.size() + held;
    ex_req = !r && !j && (total < DEPTH);
    chk("imem_req", imem_req_o, ex_req);
    chk("pc_stall", pc_stall_o, r || (!j && !(ex_req && g)));
    chk("inst_valid", inst_valid_o, !r && !j && (held != 0));
    if (imem_req_o) chk("imem_addr", imem_addr_o, pc_q);
    if (r) begin
      inflight.delete();
      exp_q.delete();
      epoch++;
    end else begin
      if (rv_fire) void'(inflight.pop_front());
      if (j) begin
        exp_q.delete();
        epoch++;
      end
      if (ex_req && g) begin
        inflight.push_back('{pc_q, epoch});
        exp_q.push_back(pc_q);
      end
    end
  endtask

  // Monitor: every accepted decode entry must be the oldest owed address with its memory word
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (inst_valid_o && inst_ready_i) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          a = exp_q.pop_front();
          chk("inst_addr", inst_addr_o, a);
          chk("inst_data", inst_o, mem_word(a));
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    // Streaming from 0x0
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Backpressure, then a single ready pulse
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Jump to 0x100 with two responses outstanding
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Jump coinciding with a response and a ready decode
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200);
    repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Grant withheld for three cycles
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Reset with two requests in flight
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4,
            $urandom_range(0, 499) == 0, AW'($urandom_range(0, 1023)) << 2);
    end
    repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
